// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag indices and entry layout for the ALU result stage
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Buffered entry; the top packs the same field order into a flat vector
    // so the FIFO stays width-agnostic.
    typedef struct packed {
        logic [ALU_W-1:0] result;
        alu_op_e          op;
        logic [3:0]       flags;
    } alu_entry_t;

    // Only the adder/subtractor produce a meaningful carry and overflow.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_fifo2.sv
// rtl/alu_fifo2.sv - 2-entry FIFO with valid/ready on both sides
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   push_valid/push_ready/data  write side; push_ready = (count != 2)
//   pop_valid/pop_ready/data    read side; pop_data is the head entry
//   count                       occupancy 0..2
//
// Slot 0 is always the head. When the FIFO empties, slot 0 is left untouched
// so the output holds its last value.
module alu_fifo2 #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         push;
    logic         pop;

    assign push_ready = (count_q != 2'd2);
    assign pop_valid  = (count_q != 2'd0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = push_data;
                end else begin
                    slot1_d = push_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    slot0_d = slot1_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at count 1: the new entry replaces the head.
                slot0_d = push_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign pop_data = slot0_q;
    assign count    = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU output stage: flag derivation, 2-entry result buffer, sticky overflow
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready                 result capture handshake
//   in_result/in_op/in_cout/in_ovf    selected result, its op code, adder carry/overflow
//   out_valid/out_ready               head entry handshake
//   out_result/out_op/out_flags       head entry; flags = {N,Z,C,V}
//   count                             buffer occupancy 0..2
//   clr_sticky/sticky_v               sticky overflow clear / status
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic [2:0]   in_op,
    input  logic         in_cout,
    input  logic         in_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [2:0]   out_op,
    output logic [3:0]   out_flags,
    output logic [1:0]   count,
    input  logic         clr_sticky,
    output logic         sticky_v
);

    localparam int ENTRY_W = N + 3 + 4;

    logic [3:0]         flags;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic               push;
    logic               sticky_q, sticky_d;

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = in_result[N-1];
        flags[FLAG_Z] = (in_result == '0);
        flags[FLAG_C] = op_is_arith(in_op) & in_cout;
        flags[FLAG_V] = op_is_arith(in_op) & in_ovf;
    end

    assign push_data = {in_result, in_op, flags};
    assign push      = in_valid && in_ready;

    alu_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (push_data),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_data),
        .count      (count)
    );

    assign {out_result, out_op, out_flags} = head_data;

    // Set takes priority over clear so an overflow in the clearing cycle is not lost.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (push && flags[FLAG_V]) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_v = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard testbench for alu_result_stage
module tb_alu_result_stage;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [2:0] in_op;
    logic       in_cout;
    logic       in_ovf;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_op;
    logic [3:0] out_flags;
    logic [1:0] count;
    logic       clr_sticky;
    logic       sticky_v;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q[$];
    bit          pend_push  = 1'b0;
    bit          exp_sticky = 1'b0;
    int          max_cnt    = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_op      (in_op),
        .in_cout    (in_cout),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .count      (count),
        .clr_sticky (clr_sticky),
        .sticky_v   (sticky_v)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: flags from the value itself; carry/overflow only mean something for add/sub.
    function automatic logic [14:0] model(input logic [7:0] r, input logic [2:0] op,
                                          input bit co, input bit ov);
        bit arith;
        bit n, z, c, v;
        arith = (op == 3'd0) || (op == 3'd1);
        n = (r >= 8'd128);
        z = (r == 8'd0);
        c = arith ? co : 1'b0;
        v = arith ? ov : 1'b0;
        return {r, op, n, z, c, v};
    endfunction

    // Monitor: at each falling edge the DUT reflects the last rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            int ec;
            logic [14:0] e;
            ec = exp_q.size() - (pend_push ? 1 : 0);
            check("count", 32'(count), 32'(ec));
            check("out_valid", 32'(out_valid), 32'(ec != 0));
            check("in_ready", 32'(in_ready), 32'(ec != 2));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("pop_entry", 32'({out_result, out_op, out_flags}), 32'(e));
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] r, input logic [2:0] op,
                         input bit co, input bit ov, input bit ordy, input bit clr);
        @(posedge clk);
        #1;
        check("sticky_v", 32'(sticky_v), 32'(exp_sticky));
        in_valid   = v;
        in_result  = r;
        in_op      = op;
        in_cout    = co;
        in_ovf     = ov;
        out_ready  = ordy;
        clr_sticky = clr;
        pend_push  = v && in_ready;
        if (pend_push) exp_q.push_back(model(r, op, co, ov));
        if (pend_push && ov && (op <= 3'd1)) exp_sticky = 1'b1;
        else if (clr) exp_sticky = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            drive(0, 8'h00, 3'd0, 0, 0, 1, 0);
        end
        drive(0, 8'h00, 3'd0, 0, 0, 1, 0);
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_result  = 8'h00;
        in_op      = 3'd0;
        in_cout    = 1'b0;
        in_ovf     = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_result", 32'(out_result), 32'(0));
        check("rst_out_op", 32'(out_op), 32'(0));
        check("rst_out_flags", 32'(out_flags), 32'(0));
        check("rst_sticky", 32'(sticky_v), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1'b1;

        // ADD zero result with carry
        drive(1, 8'h00, OP_ADD, 1, 0, 1, 0);
        drive(0, 8'h00, OP_ADD, 0, 0, 1, 0);
        check("add0_valid", 32'(out_valid), 32'(1));
        check("add0_flags", 32'(out_flags), 32'(4'b0110));
        drive(0, 8'h00, OP_ADD, 0, 0, 1, 0);
        check("add0_count", 32'(count), 32'(0));

        // AND masks carry/overflow
        drive(1, 8'h80, OP_AND, 1, 1, 1, 0);
        drive(0, 8'h00, OP_ADD, 0, 0, 1, 0);
        check("and_flags", 32'(out_flags), 32'(4'b1000));
        check("and_sticky", 32'(sticky_v), 32'(0));
        drain();

        // Backpressure: three offered, two accepted
        drive(1, 8'd1, OP_OR, 0, 0, 0, 0);
        drive(1, 8'd2, OP_OR, 0, 0, 0, 0);
        drive(1, 8'd3, OP_OR, 0, 0, 0, 0);
        check("full_count", 32'(count), 32'(2));
        check("full_in_ready", 32'(in_ready), 32'(0));
        drive(0, 8'd0, OP_OR, 0, 0, 1, 0);
        drive(0, 8'd0, OP_OR, 0, 0, 1, 0);
        check("full_pop_in_ready", 32'(in_ready), 32'(1));
        drain();
        drive(1, 8'd3, OP_OR, 0, 0, 1, 0);
        drain();

        // Streaming
        max_cnt = 0;
        for (int i = 0; i < 8; i++) drive(1, 8'(8'h10 + i), 3'(i), 1, 1, 1, 0);
        drain();
        check("stream_max_le1", 32'(max_cnt <= 1), 32'(1));
        drive(0, 8'h00, 3'd0, 0, 0, 1, 1);

        // Sticky set/clear priority
        drive(1, 8'h7f, OP_SUB, 0, 1, 1, 0);
        drive(1, 8'h80, OP_SUB, 0, 1, 1, 1);
        check("sticky_set", 32'(sticky_v), 32'(1));
        drive(0, 8'h00, OP_ADD, 0, 0, 1, 1);
        check("sticky_set_wins", 32'(sticky_v), 32'(1));
        drive(0, 8'h00, OP_ADD, 0, 0, 1, 0);
        check("sticky_clr", 32'(sticky_v), 32'(0));
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end
        drain();

        // Reset while full
        drive(1, 8'hA5, OP_XOR, 0, 0, 0, 0);
        drive(1, 8'h5A, OP_XOR, 0, 0, 0, 0);
        drive(0, 8'h00, OP_XOR, 0, 0, 0, 0);
        check("pre_rst_count", 32'(count), 32'(2));
        #1;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        exp_q.delete();
        pend_push  = 1'b0;
        exp_sticky = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_flags", 32'(out_flags), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1'b1;
        drive(1, 8'h01, OP_ADD, 1, 1, 1, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Output stage of the ALU, directly downstream of the 8-way result multiplexer. Takes the selected result and its operation code, derives the N/Z/C/V status flags, and buffers result plus flags in a 2-entry FIFO behind a valid/ready handshake, so the ALU keeps issuing while the consumer stalls. Also keeps a sticky overflow bit for software polling.

## Interface
Parameters:
- `N`, 8, result/operand width (matches the multiplexer width).

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  mux output holds a result to capture.
- `in_ready`  out  1  stage can accept; equals (count != 2).
- `in_result`  in  N  result from the 8-way multiplexer.
- `in_op`  in  3  the multiplexer select that produced `in_result`.
- `in_cout`  in  1  adder/subtractor carry-out (borrow-inverted for SUB).
- `in_ovf`  in  1  adder/subtractor signed overflow.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer takes head entry this cycle.
- `out_result`  out  N  head result.
- `out_op`  out  3  head op code.
- `out_flags`  out  4  head flags {N,Z,C,V}, bit 3 = N.
- `count`  out  2  occupancy 0..2.
- `clr_sticky`  in  1  clear the sticky overflow bit.
- `sticky_v`  out  1  set by any accepted result whose V = 1.

## Operation
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- Flags computed combinationally at push, stored with the entry:
  - N = `in_result[N-1]`; Z = (`in_result` == 0).
  - C = `in_cout`, V = `in_ovf` only for OP_ADD (000) and OP_SUB (001); else C = V = 0.
- FIFO order strictly preserved; head presented on `out_*` whenever count > 0.
- count: 0 -> 1 on push only, 1 -> 0 on pop only, 1 -> 2 on push only, 2 -> 1 on pop only; push+pop together leaves count unchanged (legal only at count 1; at count 0 there is nothing to pop, at count 2 `in_ready` = 0).
- Push at count 1 with simultaneous pop: new entry becomes head next cycle.
- `out_*` data when `out_valid` = 0: hold last value; consumers must ignore it.
- Sticky: set on push with V = 1; cleared by `clr_sticky`; both in same cycle -> set wins (sticky = 1).
- `in_*` sampled only on push; changes while `in_ready` = 0 ignored.

## Timing
- Reset (async assert, sync-safe deassert): count = 0, `out_valid` = 0, `out_result` = 0, `out_op` = 0, `out_flags` = 0, `sticky_v` = 0, `in_ready` = 1.
- Latency: push at edge k into an empty FIFO -> `out_valid` = 1 with that data from edge k until popped (1 cycle).
- Throughput: 1 result/cycle sustained when `out_ready` held high.
- `in_ready` depends only on registered count; no combinational path `out_ready` -> `in_ready`.
- Full (count 2) + `out_ready` = 1: pop at edge, `in_ready` = 1 the following cycle.
- Reset mid-operation: all buffered entries discarded; no partial output.

## Structure
- Package `alu_pkg`: op enum (OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_SHL=101, OP_SHR=110, OP_NOT=111), flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, packed entry struct {result, op, flags}.
- Sub-module `alu_fifo2`: 2-entry storage + count/pointers, parameterised on entry width; top holds flag logic and sticky bit.

## Test plan
- Reset then push ADD result 8'h00, cout=1, ovf=0, `out_ready`=1 -> next cycle `out_valid`=1, flags 4'b0110, count back to 0 after pop.
- AND result 8'h80 with cout=1, ovf=1 -> flags 4'b1000 (C,V masked), `sticky_v` stays 0.
- `out_ready`=0, push three results 1,2,3 -> first two accepted, `in_ready`=0 on third, count=2; raise `out_ready` -> outputs 1,2 then 3 in order.
- Streaming 8 pushes with `out_ready`=1 -> one result per cycle, count never exceeds 1.
- SUB with ovf=1 sets `sticky_v`; same-cycle `clr_sticky` with another ovf=1 push -> remains 1; lone `clr_sticky` -> 0.
- Assert `rst_n`=0 at count=2 -> `out_valid`, count, flags drop to 0 immediately, `in_ready`=1.
